// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and the command FSM.
//   uart_state_e : receiver FSM state encoding (also exported for debug)
//   BR_DEFAULT   : default clocks per bit (50 MHz / 115200)
//   PARITY_EVEN / PARITY_ODD : values for a receiver's parity-sense parameter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int BR_DEFAULT = 434;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: generic two-flop synchroniser for a single asynchronous bit.
//   clk     : destination clock
//   rst     : synchronous, active-high reset; both flops load RST_VAL
//   d       : asynchronous input
//   q       : synchronised output, two clocks behind d
module uart_sync2 #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver, 8N1 / 8E1 / 8O1 style frames, mid-bit sampling.
//   clk        : clock
//   rst        : synchronous, active-high reset
//   rx         : asynchronous serial line, idles high
//   rx_data    : received byte, held while rx_vld
//   rx_vld     : byte available
//   rx_rdy     : consumer accepts the byte
//   parity_err : parity mismatch for the held byte (0 when PARITY_EN = 0)
//   frame_err  : stop bit of the held byte was sampled low
//   overrun    : one-cycle pulse when a completed byte is dropped
//   state_dbg  : current FSM state, for observation only
//
// Handshake: a byte transfers on every cycle where rx_vld and rx_rdy are both
// high. While rx_vld is high and rx_rdy is low, rx_data, parity_err and
// frame_err are frozen. rx_rdy has no effect while rx_vld is low.
module uart_rx_frame #(
  parameter int BR         = uart_pkg::BR_DEFAULT,
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = uart_pkg::PARITY_EVEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [DATA_WIDTH-1:0]  rx_data,
  output logic                   rx_vld,
  input  logic                   rx_rdy,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun,
  output uart_pkg::uart_state_e  state_dbg
);

  localparam int HB    = BR / 2;
  localparam int BR_W  = $clog2(BR);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BR_W-1:0]  BR_LAST  = BR_W'(BR - 1);
  localparam logic [BR_W-1:0]  HB_LAST  = BR_W'(HB - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  uart_pkg::uart_state_e  state;
  logic                   rx_s;
  logic                   rx_q;
  logic [1:0]             sync_fill;
  logic [BR_W-1:0]        br_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  shift;
  logic                   perr_q;
  logic                   br_done;
  logic                   commit;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign br_done   = (br_cnt == BR_LAST);
  // The stop bit is sampled and the byte committed in the same cycle.
  assign commit    = (state == uart_pkg::ST_STOP) && br_done;
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Edge detector, counters, FSM, shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= uart_pkg::ST_IDLE;
      rx_q      <= 1'b0;
      sync_fill <= 2'd0;
      br_cnt    <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      perr_q    <= 1'b0;
    end else begin
      // The synchroniser leaves reset holding 1s that were never sampled from
      // the pin. rx_q stays 0 until both flops hold real samples, so a line
      // that is low through reset must genuinely go high before a start edge
      // can be recognised.
      if (sync_fill != 2'd2) begin
        sync_fill <= sync_fill + 2'd1;
      end
      rx_q <= (sync_fill == 2'd2) ? rx_s : 1'b0;

      br_cnt <= br_cnt + BR_W'(1);

      case (state)
        uart_pkg::ST_IDLE: begin
          br_cnt <= '0;
          if (rx_q && !rx_s) begin
            state <= uart_pkg::ST_START;
          end
        end

        uart_pkg::ST_START: begin
          // Half a bit in: a line already back high was a glitch.
          if (br_cnt == HB_LAST) begin
            br_cnt  <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? uart_pkg::ST_IDLE : uart_pkg::ST_DATA;
          end
        end

        uart_pkg::ST_DATA: begin
          if (br_done) begin
            br_cnt         <= '0;
            shift[bit_cnt] <= rx_s;
            bit_cnt        <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              state <= PARITY_EN ? uart_pkg::ST_PARITY : uart_pkg::ST_STOP;
            end
          end
        end

        uart_pkg::ST_PARITY: begin
          if (br_done) begin
            br_cnt <= '0;
            perr_q <= (^shift) ^ rx_s ^ PARITY_ODD;
            state  <= uart_pkg::ST_STOP;
          end
        end

        uart_pkg::ST_STOP: begin
          // Return to IDLE at mid-stop so a following start edge is not missed.
          if (br_done) begin
            br_cnt <= '0;
            state  <= uart_pkg::ST_IDLE;
          end
        end

        default: begin
          state <= uart_pkg::ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register and handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_vld     <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        // A commit that coincides with an accept replaces the byte and keeps
        // rx_vld high; a commit against a stalled byte is dropped.
        if (!rx_vld || rx_rdy) begin
          rx_data    <= shift;
          parity_err <= PARITY_EN & perr_q;
          frame_err  <= ~rx_s;
          rx_vld     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_vld && rx_rdy) begin
        rx_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int BR  = 16;
  localparam int DW  = 8;
  localparam int HB  = BR / 2;
  // Pin falling edge to rx_vld: 2 sync cycles, then HB + BR*(DW+parity+stop) + 1.
  localparam int LAT = 2 + HB + BR * (DW + 2) + 1;
  localparam int NRAND = 24;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          rx_rdy;
  logic [DW-1:0] rx_data;
  logic          rx_vld;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;
  uart_state_e   state_dbg;

  always #5 clk = ~clk;

  uart_rx_frame #(
    .BR         (BR),
    .DATA_WIDTH (DW),
    .PARITY_EN  (1'b1),
    .PARITY_ODD (PARITY_EVEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_vld     (rx_vld),
    .rx_rdy     (rx_rdy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Even-parity bit for a byte: 1 when the byte has an odd number of ones.
  function automatic logic even_par_bit(input logic [DW-1:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Drives the first nbits of a frame (start, data LSB first, parity, stop),
  // each held for BR clocks.
  task automatic send_frame(input logic [DW-1:0] d, input logic par,
                            input logic stop, input int nbits);
    logic [DW+2:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (BR) tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard and monitors
  // ---------------------------------------------------------------------------
  logic [DW+1:0] exp_q[$];     // {parity_err, frame_err, data}
  logic [DW+1:0] sb_item;
  bit            sb_en = 1'b0;
  int            vld_rises = 0;
  int            ovr_cnt = 0;
  logic          prev_vld = 1'b0;
  logic          hold_armed = 1'b0;
  logic [DW+2:0] hold_val;

  always @(negedge clk) begin
    if (hold_armed) begin
      check("hold_stable", {rx_vld, parity_err, frame_err, rx_data}, hold_val);
    end
    hold_armed = rx_vld && !rx_rdy && !rst;
    hold_val   = {rx_vld, parity_err, frame_err, rx_data};

    if (rx_vld && !prev_vld) vld_rises++;
    prev_vld = rx_vld;
    if (overrun) ovr_cnt++;

    if (sb_en && rx_vld && rx_rdy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_byte", {parity_err, frame_err, rx_data}, 32'hFFFF_FFFF);
      end else begin
        sb_item = exp_q.pop_front();
        check("sb_byte", {parity_err, frame_err, rx_data}, sb_item);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] d;
    logic          par;
    logic          stop;
    logic [DW-1:0] exp_d;
    logic          exp_pe;
    logic          exp_fe;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int r0;
    int o0;
    logic [DW-1:0] d;
    logic          perr_inj;
    logic          stop_b;
    int            gap;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[4] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst = 1'b1;
    rx = 1'b1;
    rx_rdy = 1'b0;
    repeat (3) tick();

    // Reset state
    check("reset_vld", rx_vld, 0);
    check("reset_data", rx_data, 0);
    check("reset_perr", parity_err, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_ovr", overrun, 0);
    check("reset_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    repeat (BR) tick();

    // Single byte with exact latency and a one-cycle rx_vld pulse
    rx_rdy = 1'b1;
    fork
      send_frame(8'hA5, even_par_bit(8'hA5), 1'b1, DW + 3);
      begin
        repeat (LAT - 1) tick();
        check("lat_before", rx_vld, 0);
        tick();
        check("lat_vld", rx_vld, 1);
        check("lat_data", rx_data, 8'hA5);
        check("lat_perr", parity_err, 0);
        check("lat_ferr", frame_err, 0);
        tick();
        check("lat_pulse_end", rx_vld, 0);
      end
    join
    repeat (4) tick();

    // Glitch: 3-cycle low pulse
    r0 = vld_rises;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    tick();
    check("glitch_start_seen", state_dbg, ST_START);
    repeat (2 * BR) tick();
    check("glitch_back_idle", state_dbg, ST_IDLE);
    check("glitch_no_vld", vld_rises - r0, 0);

    // Table of single frames, held until drained
    rx_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      o0 = ovr_cnt;
      send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, DW + 3);
      rx = 1'b1;
      check("tbl_vld", rx_vld, 1);
      check("tbl_data", rx_data, tbl[i].exp_d);
      check("tbl_perr", parity_err, tbl[i].exp_pe);
      check("tbl_ferr", frame_err, tbl[i].exp_fe);
      rx_rdy = 1'b1;
      tick();
      rx_rdy = 1'b0;
      check("tbl_drain", rx_vld, 0);
      check("tbl_no_ovr", ovr_cnt - o0, 0);
      repeat (4) tick();
    end

    // Backpressure: 0x11 held, 0x22 dropped with one overrun pulse
    rx_rdy = 1'b0;
    o0 = ovr_cnt;
    r0 = vld_rises;
    send_frame(8'h11, even_par_bit(8'h11), 1'b1, DW + 3);
    send_frame(8'h22, even_par_bit(8'h22), 1'b1, DW + 3);
    check("bp_vld", rx_vld, 1);
    check("bp_data_kept", rx_data, 8'h11);
    check("bp_ovr_once", ovr_cnt - o0, 1);
    rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    check("bp_drain", rx_vld, 0);
    repeat (2 * BR) tick();
    check("bp_only_one_byte", vld_rises - r0, 1);

    // Accept in the exact commit cycle of the next byte
    send_frame(8'h11, even_par_bit(8'h11), 1'b1, DW + 3);
    o0 = ovr_cnt;
    fork
      send_frame(8'h22, even_par_bit(8'h22), 1'b1, DW + 3);
      begin
        repeat (LAT - 1) tick();
        rx_rdy = 1'b1;
        tick();
        check("sim_vld_stays", rx_vld, 1);
        check("sim_data_new", rx_data, 8'h22);
        check("sim_no_ovr_pulse", overrun, 0);
        tick();
        rx_rdy = 1'b0;
        check("sim_drain", rx_vld, 0);
      end
    join
    check("sim_no_ovr_cnt", ovr_cnt - o0, 0);
    repeat (4) tick();

    // Reset in the middle of 0x55, line held low through and after reset
    rx_rdy = 1'b1;
    send_frame(8'h55, even_par_bit(8'h55), 1'b1, 4);
    rx = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    check("mid_rst_vld", rx_vld, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_state", state_dbg, ST_IDLE);
    r0 = vld_rises;
    rst = 1'b0;
    repeat (3 * BR) tick();
    rx = 1'b1;
    repeat (2 * BR) tick();
    check("mid_rst_no_byte", vld_rises - r0, 0);
    rx_rdy = 1'b0;
    send_frame(8'h81, even_par_bit(8'h81), 1'b1, DW + 3);
    check("after_rst_vld", rx_vld, 1);
    check("after_rst_data", rx_data, 8'h81);
    check("after_rst_perr", parity_err, 0);
    check("after_rst_ferr", frame_err, 0);
    rx_rdy = 1'b1;
    tick();
    repeat (4) tick();

    // Random frames against the reference model, gaps down to zero
    r0 = vld_rises;
    sb_en = 1'b1;
    rx_rdy = 1'b1;
    for (int n = 0; n < NRAND; n++) begin
      d        = DW'($urandom_range(0, 255));
      perr_inj = ($urandom_range(0, 3) == 0);
      stop_b   = ($urandom_range(0, 4) != 0);
      exp_q.push_back({perr_inj, ~stop_b, d});
      send_frame(d, even_par_bit(d) ^ perr_inj, stop_b, DW + 3);
      rx = 1'b1;
      gap = $urandom_range(0, BR);
      // A low stop bit leaves no falling edge; the line must idle high first.
      if (!stop_b && gap < 4) gap = 4;
      repeat (gap) tick();
    end
    repeat (2 * BR) tick();
    sb_en = 1'b0;
    check("sb_all_delivered", exp_q.size(), 0);
    check("rand_byte_count", vld_rises - r0, NRAND);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Bounded run time
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
